mac_dot_sequencer: RTL and testbench
====================================

# mac_dot_sequencer

Sequencing controller that time-shares one unsigned 4x4 multiply-accumulate datapath over a stream of operand pairs to compute a biased dot product, result = bias + Σ a[i]*b[i]. It sits between a command source and an operand stream on the input side, and a result consumer on the output side. It accepts one job at a time over valid/ready handshakes and holds the accumulated result until the consumer takes it.

## Interface
- DATA_W, 4, operand and bias width (unsigned)
- LEN_W, 4, job length field width; maximum job length is 2^LEN_W-1 pairs
- ACC_W, 2*DATA_W+LEN_W (12), accumulator and result width

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- io_start_valid  in  1  job command valid
- io_start_ready  out  1  controller can accept a job
- io_start_len  in  LEN_W  number of operand pairs in the job (0 legal)
- io_start_bias  in  DATA_W  initial accumulator value
- io_op_valid  in  1  operand pair valid
- io_op_ready  out  1  controller consumes a pair this cycle
- io_op_a, io_op_b  in  DATA_W each  operand pair
- io_res_valid  out  1  result available
- io_res_ready  in  1  consumer takes the result
- io_res_data  out  ACC_W  accumulated result
- io_busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Register reset values: acc=0, cnt=0.
- Output values while in reset: io_start_ready=1, io_op_ready=0, io_res_valid=0, io_res_data=0, io_busy=0.
- IDLE:
  - io_start_ready=1; all other handshake outputs 0.
  - Start fire (valid&ready): acc <= zero-extended bias, cnt <= len.
  - Next state is DONE if len==0, else RUN.
- RUN:
  - io_op_ready=1; io_start_ready=0.
  - Op fire: acc <= acc + zext(a*b). The product is a full 2*DATA_W-bit unsigned value, zero-extended to ACC_W. Also cnt <= cnt-1.
  - Op fire while cnt==1: next state is DONE.
  - No op fire: state, acc and cnt hold. Gaps in io_op_valid are legal.
- DONE:
  - io_res_valid=1 and io_res_data=acc, held stable until fire.
  - Res fire: next state is IDLE. acc is not cleared; it is overwritten by the next start.
- io_op_ready is 0 outside RUN. Pairs offered outside RUN are not consumed.
- io_start_len and io_start_bias are sampled only on start fire. Changes at any other time have no effect.
- Arithmetic is unsigned modulo 2^ACC_W. With the default parameters the worst case is 15*225+15 = 3390 < 4096, so no wrap occurs.
- All handshake outputs are decoded from the state register only. There are no combinational paths from inputs to outputs.

## Timing
- Start fire at cycle t: io_op_ready=1 from t+1 (len>0), or io_res_valid=1 from t+1 (len==0).
- Throughput: one pair per cycle while io_op_valid stays high.
- Last pair accepted at cycle k: io_res_valid=1 at k+1, carrying the sum including that pair.
- Res fire at cycle r: io_start_ready=1 at r+1. There is no same-cycle start on the result-fire cycle.
- Minimum job period is len+2 cycles.
- Reset asserted mid-job: the job is abandoned and outputs go to their reset values asynchronously. After deassertion the controller is in IDLE, with no partial result emitted.
- io_res_ready held low in DONE: the result is held indefinitely and no new start is accepted.

## Test plan
- Basic job: start len=3, bias=2; pairs (3,4),(5,6),(1,1) back-to-back.
  - io_res_data=45, with io_res_valid one cycle after the third pair.
  - io_op_ready low on the cycle after the third pair.
- Zero length: start len=0, bias=9.
  - io_res_valid at t+1 with io_res_data=9.
  - io_op_ready never asserts.
- Stalls:
  - Job len=2, bias=0, pairs (7,7),(2,3), with io_op_valid low for 3 cycles between pairs: result 55, acc unchanged during the gap.
  - io_res_ready held low for 5 cycles: io_res_data stays 55, io_start_ready stays 0, result fires on the first ready cycle.
- Maximum accumulation: len=15, bias=15, all pairs (15,15): io_res_data=3390 after exactly 15 op fires.
- Reset mid-run: start len=4, 2 pairs accepted, then reset pulsed.
  - io_busy=0 and io_res_valid=0 immediately.
  - A following job len=1, bias=1, pair (2,2) returns 5.
- Back-to-back jobs: result fire at r, new start offered from r.
  - Start accepted at r+1, not at r.
  - The second result is independent of the first: acc is reloaded with the new bias.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Sequencing controller that time-shares one unsigned multiply-accumulate
// datapath over a stream of operand pairs: result = bias + sum(a[i]*b[i]).
module mac_dot_sequencer #(
  parameter int DATA_W = 4,
  parameter int LEN_W  = 4,
  parameter int ACC_W  = 2*DATA_W + LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start_valid,
  output logic              io_start_ready,
  input  logic [LEN_W-1:0]  io_start_len,
  input  logic [DATA_W-1:0] io_start_bias,
  input  logic              io_op_valid,
  output logic              io_op_ready,
  input  logic [DATA_W-1:0] io_op_a,
  input  logic [DATA_W-1:0] io_op_b,
  output logic              io_res_valid,
  input  logic              io_res_ready,
  output logic [ACC_W-1:0]  io_res_data,
  output logic              io_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    bias_ext;
  logic                start_fire;
  logic                op_fire;
  logic                res_fire;

  assign prod     = io_op_a * io_op_b;
  assign prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){1'b0}}, io_start_bias};

  // Handshake outputs depend on the state register alone, so no input reaches an output combinationally.
  assign io_start_ready = (state_q == IDLE);
  assign io_op_ready    = (state_q == RUN);
  assign io_res_valid   = (state_q == DONE);
  assign io_busy        = (state_q == RUN) || (state_q == DONE);
  assign io_res_data    = (state_q == DONE) ? acc_q : '0;

  assign start_fire = io_start_valid && (state_q == IDLE);
  assign op_fire    = io_op_valid    && (state_q == RUN);
  assign res_fire   = io_res_ready   && (state_q == DONE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_fire) begin
          acc_d   = bias_ext;
          cnt_d   = io_start_len;
          state_d = (io_start_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (op_fire) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // acc is left as is; the next start overwrites it with the new bias.
        if (res_fire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer: directed jobs push hand-computed
// results into a queue that a negedge monitor pops on every result fire.
module tb_mac_dot_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_start_valid;
  logic        io_start_ready;
  logic [3:0]  io_start_len;
  logic [3:0]  io_start_bias;
  logic        io_op_valid;
  logic        io_op_ready;
  logic [3:0]  io_op_a;
  logic [3:0]  io_op_b;
  logic        io_res_valid;
  logic        io_res_ready;
  logic [11:0] io_res_data;
  logic        io_busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  mac_dot_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .io_start_valid (io_start_valid),
    .io_start_ready (io_start_ready),
    .io_start_len   (io_start_len),
    .io_start_bias  (io_start_bias),
    .io_op_valid    (io_op_valid),
    .io_op_ready    (io_op_ready),
    .io_op_a        (io_op_a),
    .io_op_b        (io_op_b),
    .io_res_valid   (io_res_valid),
    .io_res_ready   (io_res_ready),
    .io_res_data    (io_res_data),
    .io_busy        (io_busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting, expected handshake within 50 cycles", name);
  endtask

  // Monitor: pop on result fire, otherwise the held result must match the head.
  always @(negedge clock) begin
    if (!reset && io_res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got %0d, expected no result", io_res_data);
      end else if (io_res_ready) begin
        checkOutput("res_data", int'(io_res_data), exp_q.pop_front());
      end else begin
        checkOutput("res_data_held", int'(io_res_data), exp_q[0]);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] len, input logic [3:0] bias, input int expv);
    int n;
    io_start_len   = len;
    io_start_bias  = bias;
    io_start_valid = 1'b1;
    exp_q.push_back(expv);
    for (n = 0; n < 50; n++) begin
      @(negedge clock);
      if (io_start_ready) break;
    end
    if (n == 50) timeoutFail("start_handshake");
    @(posedge clock);
    #1;
    io_start_valid = 1'b0;
    io_start_len   = 4'hf;
    io_start_bias  = 4'hf;
  endtask

  task automatic sendOp(input logic [3:0] a, input logic [3:0] b);
    int n;
    io_op_a     = a;
    io_op_b     = b;
    io_op_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clock);
      if (io_op_ready) break;
    end
    if (n == 50) timeoutFail("op_handshake");
    @(posedge clock);
    #1;
  endtask

  task automatic waitIdle();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clock);
      if (io_start_ready) break;
    end
    if (n == 50) timeoutFail("wait_idle");
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    io_start_valid = 1'b0;
    io_start_len   = 4'd0;
    io_start_bias  = 4'd0;
    io_op_valid    = 1'b0;
    io_op_a        = 4'd0;
    io_op_b        = 4'd0;
    io_res_ready   = 1'b1;

    repeat (2) @(negedge clock);
    checkOutput("rst_start_ready", int'(io_start_ready), 1);
    checkOutput("rst_op_ready", int'(io_op_ready), 0);
    checkOutput("rst_res_valid", int'(io_res_valid), 0);
    checkOutput("rst_res_data", int'(io_res_data), 0);
    checkOutput("rst_busy", int'(io_busy), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Basic job: 2 + 12 + 30 + 1 = 45
    applyStimulus(4'd3, 4'd2, 45);
    checkOutput("basic_busy", int'(io_busy), 1);
    sendOp(4'd3, 4'd4);
    sendOp(4'd5, 4'd6);
    sendOp(4'd1, 4'd1);
    io_op_valid = 1'b0;
    @(negedge clock);
    checkOutput("basic_op_ready_after", int'(io_op_ready), 0);
    checkOutput("basic_res_valid", int'(io_res_valid), 1);
    waitIdle();

    // Zero length, with pairs offered that must not be consumed
    io_op_a     = 4'd15;
    io_op_b     = 4'd15;
    io_op_valid = 1'b1;
    applyStimulus(4'd0, 4'd9, 9);
    @(negedge clock);
    checkOutput("zero_res_valid", int'(io_res_valid), 1);
    checkOutput("zero_op_ready", int'(io_op_ready), 0);
    waitIdle();
    io_op_valid = 1'b0;

    // Stalls on both sides: 49 + 6 = 55
    io_res_ready = 1'b0;
    applyStimulus(4'd2, 4'd0, 55);
    sendOp(4'd7, 4'd7);
    io_op_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checkOutput("gap_op_ready", int'(io_op_ready), 1);
      @(posedge clock);
      #1;
    end
    sendOp(4'd2, 4'd3);
    io_op_valid = 1'b0;
    repeat (5) begin
      @(negedge clock);
      checkOutput("hold_res_valid", int'(io_res_valid), 1);
      checkOutput("hold_start_ready", int'(io_start_ready), 0);
      @(posedge clock);
      #1;
    end
    io_res_ready = 1'b1;
    @(negedge clock);
    checkOutput("release_res_valid", int'(io_res_valid), 1);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("release_start_ready", int'(io_start_ready), 1);
    @(posedge clock);
    #1;

    // Maximum accumulation: 15 + 15*225 = 3390
    applyStimulus(4'd15, 4'd15, 3390);
    for (int i = 0; i < 15; i++) sendOp(4'd15, 4'd15);
    io_op_valid = 1'b0;
    @(negedge clock);
    checkOutput("max_res_valid", int'(io_res_valid), 1);
    checkOutput("max_op_ready", int'(io_op_ready), 0);
    waitIdle();

    // Reset mid-run abandons the job
    applyStimulus(4'd4, 4'd3, 5);
    sendOp(4'd1, 4'd1);
    sendOp(4'd1, 4'd1);
    io_op_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", int'(io_busy), 0);
    checkOutput("midrst_res_valid", int'(io_res_valid), 0);
    checkOutput("midrst_op_ready", int'(io_op_ready), 0);
    checkOutput("midrst_start_ready", int'(io_start_ready), 1);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(4'd1, 4'd1, 5);
    sendOp(4'd2, 4'd2);
    io_op_valid = 1'b0;
    waitIdle();

    // Back-to-back: 1 + 4 + 9 = 14, then 4 + 25 = 29
    applyStimulus(4'd2, 4'd1, 14);
    sendOp(4'd2, 4'd2);
    sendOp(4'd3, 4'd3);
    io_op_valid    = 1'b0;
    io_start_len   = 4'd1;
    io_start_bias  = 4'd4;
    io_start_valid = 1'b1;
    exp_q.push_back(29);
    @(negedge clock);
    checkOutput("b2b_res_valid_r", int'(io_res_valid), 1);
    checkOutput("b2b_start_ready_r", int'(io_start_ready), 0);
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("b2b_start_ready_r1", int'(io_start_ready), 1);
    @(posedge clock);
    #1;
    io_start_valid = 1'b0;
    sendOp(4'd5, 4'd5);
    io_op_valid = 1'b0;
    waitIdle();

    repeat (2) @(posedge clock);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
